// File: rtl/uart_cmd_parser_if.sv
// Handshake bundle between UART_RX, the command parser and the measurement control logic.
// slave = parser side, master = the surrounding system (receiver plus command consumer).
interface uart_cmd_parser_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      rx_data;
    logic            rx_data_valid;
    logic            rx_data_ready;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [7:0]      cmd_code;
    logic [ADDR_W:0] cmd_len;
    logic [ADDR_W-1:0] pl_rd_addr;
    logic [7:0]      pl_rd_data;
    logic            frame_err;
    logic            timeout_err;
    logic [15:0]     err_cnt;

    modport slave (
        input  rx_data, rx_data_valid, cmd_ready, pl_rd_addr,
        output rx_data_ready, cmd_valid, cmd_code, cmd_len, pl_rd_data,
               frame_err, timeout_err, err_cnt
    );

    modport master (
        output rx_data, rx_data_valid, cmd_ready, pl_rd_addr,
        input  rx_data_ready, cmd_valid, cmd_code, cmd_len, pl_rd_data,
               frame_err, timeout_err, err_cnt
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Decodes 55 AA CMD LEN PAYLOAD CHK frames from UART_RX and holds each valid command until taken.
// Define UART_CMD_PARSER_ERRCNT_EN to build the saturating 16-bit error counter on err_cnt.
module uart_cmd_parser #(
    parameter int          MAX_LEN        = 16,
    parameter int          ADDR_W         = 4,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
    input logic clk_50m,
    input logic rst,
    uart_cmd_parser_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR2, CMD, LEN, PAYLOAD, CHK, HOLD} state_t;

    localparam logic [ADDR_W:0] IDX_ONE = 1;
    localparam logic [8:0]      MAX_LEN_B = 9'(MAX_LEN);

    state_t            state_reg, state_next;
    logic [7:0]        code_reg;
    logic [7:0]        sum_reg;
    logic [ADDR_W:0]   len_reg;
    logic [ADDR_W:0]   idx_reg;
    logic [19:0]       to_cnt_reg;
    logic              frame_err_reg, frame_err_next;
    logic              timeout_err_reg, timeout_err_next;
    logic [7:0]        pl_mem [2**ADDR_W];

    logic              accept;
    logic              timed;
    logic              to_hit;
    logic [ADDR_W:0]   idx_inc;
    logic              rx_ready_out;
    logic              cmd_valid_out;

    assign accept  = bus.rx_data_valid && rx_ready_out;
    assign timed   = (state_reg != IDLE) && (state_reg != HOLD);
    // A byte arriving on the terminal-count cycle wins over the timeout.
    assign to_hit  = timed && !accept && (to_cnt_reg == TIMEOUT_CYCLES - 20'd1);
    assign idx_inc = idx_reg + IDX_ONE;

    always_ff @(posedge clk_50m) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next       = state_reg;
        frame_err_next   = 1'b0;
        timeout_err_next = 1'b0;
        if (to_hit) begin
            state_next       = IDLE;
            timeout_err_next = 1'b1;
        end else if (state_reg == HOLD) begin
            if (bus.cmd_ready) state_next = IDLE;
        end else if (accept) begin
            case (state_reg)
                IDLE: if (bus.rx_data == 8'h55) state_next = HDR2;
                HDR2: begin
                    if (bus.rx_data == 8'hAA)      state_next = CMD;
                    else if (bus.rx_data == 8'h55) state_next = HDR2;
                    else                           state_next = IDLE;
                end
                CMD: state_next = LEN;
                LEN: begin
                    if ({1'b0, bus.rx_data} > MAX_LEN_B) begin
                        state_next     = IDLE;
                        frame_err_next = 1'b1;
                    end else if (bus.rx_data == 8'h00) begin
                        state_next = CHK;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
                PAYLOAD: if (idx_inc == len_reg) state_next = CHK;
                CHK: begin
                    if (bus.rx_data == sum_reg) begin
                        state_next = HOLD;
                    end else begin
                        state_next     = IDLE;
                        frame_err_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_ready_out  = (state_reg != HOLD);
        cmd_valid_out = (state_reg == HOLD);
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            code_reg        <= 8'h00;
            sum_reg         <= 8'h00;
            len_reg         <= '0;
            idx_reg         <= '0;
            to_cnt_reg      <= 20'd0;
            frame_err_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            frame_err_reg   <= frame_err_next;
            timeout_err_reg <= timeout_err_next;
            if (!timed || accept || to_hit) to_cnt_reg <= 20'd0;
            else                            to_cnt_reg <= to_cnt_reg + 20'd1;
            if (accept) begin
                case (state_reg)
                    CMD: begin
                        code_reg <= bus.rx_data;
                        sum_reg  <= bus.rx_data;
                    end
                    LEN: begin
                        sum_reg <= sum_reg + bus.rx_data;
                        len_reg <= bus.rx_data[ADDR_W:0];
                        idx_reg <= '0;
                    end
                    PAYLOAD: begin
                        sum_reg <= sum_reg + bus.rx_data;
                        idx_reg <= idx_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Payload store is never reset; the consumer only reads it while a command is held.
    always_ff @(posedge clk_50m) begin
        if (accept && state_reg == PAYLOAD) pl_mem[idx_reg[ADDR_W-1:0]] <= bus.rx_data;
    end

`ifdef UART_CMD_PARSER_ERRCNT_EN
    logic [15:0] err_cnt_reg;
    always_ff @(posedge clk_50m) begin
        if (rst)
            err_cnt_reg <= 16'h0000;
        else if ((frame_err_reg || timeout_err_reg) && err_cnt_reg != 16'hFFFF)
            err_cnt_reg <= err_cnt_reg + 16'h0001;
    end
    assign bus.err_cnt = err_cnt_reg;
`else
    assign bus.err_cnt = 16'h0000;
`endif

    assign bus.rx_data_ready = rx_ready_out;
    assign bus.cmd_valid     = cmd_valid_out;
    assign bus.cmd_code      = code_reg;
    assign bus.cmd_len       = len_reg;
    assign bus.pl_rd_data    = pl_mem[bus.pl_rd_addr];
    assign bus.frame_err     = frame_err_reg;
    assign bus.timeout_err   = timeout_err_reg;
endmodule
